// File: rtl/store_merge_rmw.sv
// Read-modify-write store unit: full-word stores go straight to memory,
// byte/halfword stores read the aligned word, merge the new lane at the
// address byte offset and write the merged word back. All outputs registered.
module store_merge_rmw #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic [1:0]        controleSS,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int LB = $clog2(DATA_W / 8);
  localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  localparam logic [1:0] SS_WORD = 2'b00;
  localparam logic [1:0] SS_BYTE = 2'b01;
  localparam logic [1:0] SS_HALF = 2'b10;

  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [LB-1:0]     off_reg, off_next;
  logic              half_reg, half_next;
  logic [15:0]       data_reg, data_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_next;
  logic              mem_we_next, busy_next, done_next, err_next;

  logic              req_bad;
  logic [ADDR_W-1:0] addr_aligned;
  logic [LB-1:0]     lane_off;
  logic [LB+2:0]     lane_shamt;
  logic [DATA_W-1:0] lane_mask, lane_val, merged;

  // Request decode and lane merge of the sampled read word
  always_comb begin
    req_bad      = (controleSS == 2'b11) ||
                   ((controleSS == SS_HALF) && addr[0]) ||
                   ((controleSS == SS_WORD) && (addr[LB-1:0] != '0));
    addr_aligned = {addr[ADDR_W-1:LB], {LB{1'b0}}};
    // A halfword lane starts at the even byte offset below the address
    lane_off     = half_reg ? (off_reg & ~LB'(1)) : off_reg;
    lane_shamt   = {lane_off, 3'b000};
    lane_mask    = (half_reg ? DATA_W'(16'hFFFF) : DATA_W'(8'hFF)) << lane_shamt;
    lane_val     = (half_reg ? DATA_W'(data_reg) : DATA_W'(data_reg[7:0])) << lane_shamt;
    merged       = (mem_rdata & ~lane_mask) | lane_val;
  end

  // Next-state and next-output logic
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    off_next       = off_reg;
    half_next      = half_reg;
    data_next      = data_reg;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    mem_we_next    = 1'b0;
    busy_next      = busy;
    done_next      = 1'b0;
    err_next       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          off_next  = addr[LB-1:0];
          half_next = (controleSS == SS_HALF);
          data_next = store_data[15:0];
          if (req_bad) begin
            state_next = ERR;
            done_next  = 1'b1;
            err_next   = 1'b1;
            busy_next  = 1'b0;
          end else if (controleSS == SS_WORD) begin
            state_next     = WRITE;
            mem_addr_next  = addr_aligned;
            mem_wdata_next = store_data;
            mem_we_next    = 1'b1;
            busy_next      = 1'b1;
          end else begin
            state_next    = READ;
            mem_addr_next = addr_aligned;
            cnt_next      = CW'(MEM_LAT);
            busy_next     = 1'b1;
          end
        end
      end
      READ: begin
        // Read data is valid once the counter has run down from MEM_LAT
        if (cnt_reg == '0) begin
          state_next     = WRITE;
          mem_wdata_next = merged;
          mem_we_next    = 1'b1;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      WRITE: begin
        state_next = DONE;
        done_next  = 1'b1;
        busy_next  = 1'b0;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      off_reg   <= '0;
      half_reg  <= 1'b0;
      data_reg  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      off_reg   <= off_next;
      half_reg  <= half_next;
      data_reg  <= data_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      mem_we    <= mem_we_next;
      busy      <= busy_next;
      done      <= done_next;
      err       <= err_next;
    end
  end

endmodule
